fifo_frame_reader: RTL and testbench

FIFO_FRAME_READER -- requirements
Module: fifo_frame_reader

---
 rtl/fifo_frame_reader_pkg.sv | 15 +
 rtl/fifo_rd_skid.sv | 60 ++++++
 rtl/fifo_frame_reader.sv | 125 ++++++++++++
 tb/tb_fifo_frame_reader.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_frame_reader_pkg.sv
// Shared types and default widths for the FIFO frame reader.
// Imported by the top level and the skid buffer.
package fifo_frame_reader_pkg;

  localparam int DEF_DATA_WIDTH = 11;
  localparam int DEF_LEN_WIDTH  = 14;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Small circular buffer that absorbs FIFO read data in flight
// while the downstream consumer is stalled.
module fifo_rd_skid
  import fifo_frame_reader_pkg::*;
#(
  parameter int depth = 2,
  parameter int width = DEF_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic [width-1:0]             data,
  input  logic                         pop,
  output logic                         empty,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic [width-1:0]             q
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [PW-1:0] LAST = PW'(depth - 1);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < depth; i++)
        mem[i] <= '0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= data;
        wp      <= nxt(wp);
      end
      if (pop)
        rp <= nxt(rp);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign q     = mem[rp];

endmodule

// File: rtl/fifo_frame_reader.sv
// Reads one frame of samples from a FIFO read port and streams
// it out on a valid/ready interface, marking the last sample.
module fifo_frame_reader
  import fifo_frame_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  abort,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int DEPTH = RD_LATENCY + 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  state_t                  state;
  state_t                  state_nx;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    issue_cnt;
  logic [LEN_WIDTH-1:0]    acc_cnt;
  logic [RD_LATENCY-1:0]   vpipe;
  logic [CW-1:0]           sk_count;
  logic [CW-1:0]           in_flight;
  logic [CW:0]             occ;
  logic                    sk_empty;
  logic [DATA_WIDTH-1:0]   sk_q;
  logic                    push;
  logic                    pop;
  logic                    start_ok;
  logic                    last_issue;

  fifo_rd_skid #(
    .depth (DEPTH),
    .width (DATA_WIDTH)
  ) u_skid (
    .clk   (rd_clk),
    .rst   (rd_rst),
    .clr   (abort),
    .push  (push),
    .data  (fifo_rd_data),
    .pop   (pop),
    .empty (sk_empty),
    .count (sk_count),
    .q     (sk_q)
  );

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      in_flight = in_flight + CW'(vpipe[i]);
  end

  // Occupancy counts the slot freed by this cycle's pop so the
  // reader can keep one sample per cycle flowing.
  assign occ = {1'b0, sk_count} + {1'b0, in_flight}
             - (CW + 1)'(pop);

  assign start_ok   = (state == IDLE) && start && !abort;
  assign last_issue = (issue_cnt == len_q - LEN_WIDTH'(1));

  assign fifo_rd_en = (state == RUN) && !abort && !fifo_rd_empty
                   && (issue_cnt < len_q) && (occ < DEPTH_V);

  assign push    = vpipe[RD_LATENCY-1] && !abort;
  assign m_valid = !sk_empty && !abort;
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? sk_q : '0;
  assign m_last  = m_valid && (acc_cnt == len_q - LEN_WIDTH'(1));

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start_ok) state_nx = RUN;
      RUN:   if (fifo_rd_en && last_issue) state_nx = FLUSH;
      FLUSH: if (pop && m_last) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort)
      state_nx = IDLE;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state     <= IDLE;
      len_q     <= LEN_WIDTH'(1);
      issue_cnt <= '0;
      acc_cnt   <= '0;
      vpipe     <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        len_q     <= (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
        issue_cnt <= '0;
        acc_cnt   <= '0;
      end else begin
        if (fifo_rd_en)
          issue_cnt <= issue_cnt + LEN_WIDTH'(1);
        if (pop)
          acc_cnt <= acc_cnt + LEN_WIDTH'(1);
      end
      // Dropping the pipeline discards reads that return after abort.
      vpipe <= abort ? '0
             : ((vpipe << 1) | RD_LATENCY'(fifo_rd_en));
    end
  end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader: read latency 1 and 2 instances
// run side by side against one FIFO content model.
module tb_fifo_frame_reader;

  typedef struct {
    int len;
    int rdy;
    int n;
    int base;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        m_ready;
  logic [13:0] frame_len;

  logic        rd_en   [2];
  logic        empty   [2];
  logic [10:0] rd_data [2];
  logic        m_valid [2];
  logic [10:0] m_data  [2];
  logic        m_last  [2];
  logic        busy    [2];
  logic        fdone   [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [10:0] fmem [64];
  int          ftail = 0;
  int          fhead [2] = '{0, 0};
  logic        fflush = 1'b0;
  logic [10:0] d1 [2] = '{11'd0, 11'd0};
  logic [10:0] d2 [2] = '{11'd0, 11'd0};

  int          ncap     [2];
  int          rdcnt    [2];
  int          ndone    [2];
  int          first_v  [2];
  int          first_a  [2];
  int          last_a   [2];
  int          done_cyc [2];
  logic        stalled  [2];
  logic [10:0] hold_d   [2];
  logic        hold_l   [2];
  logic [10:0] capd [2][32];
  logic        capl [2][32];
  int          start_edge;

  vec_t vecs [6];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    fifo_frame_reader #(
      .DATA_WIDTH (11),
      .LEN_WIDTH  (14),
      .RD_LATENCY (k + 1)
    ) dut (
      .rd_clk        (clk),
      .rd_rst        (rst),
      .start         (start),
      .frame_len     (frame_len),
      .abort         (abort),
      .fifo_rd_en    (rd_en[k]),
      .fifo_rd_data  (rd_data[k]),
      .fifo_rd_empty (empty[k]),
      .m_valid       (m_valid[k]),
      .m_ready       (m_ready),
      .m_data        (m_data[k]),
      .m_last        (m_last[k]),
      .busy          (busy[k]),
      .frame_done    (fdone[k])
    );
  end

  assign empty[0]   = (fhead[0] == ftail);
  assign empty[1]   = (fhead[1] == ftail);
  assign rd_data[0] = d1[0];
  assign rd_data[1] = d2[1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (fflush)
        fhead[k] <= ftail;
      else if (rd_en[k]) begin
        d1[k]    <= fmem[fhead[k] & 63];
        fhead[k] <= fhead[k] + 1;
      end
      d2[k] <= d1[k];
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (rd_en[k]) begin
          rdcnt[k]++;
          checks++;
          if (empty[k]) begin
            errors++;
            $display("FAIL rd_while_empty L%0d: rd_en=1 empty=1 want no read", k + 1);
          end
        end
        if (stalled[k]) begin
          checks++;
          if (!m_valid[k] || m_data[k] !== hold_d[k] || m_last[k] !== hold_l[k]) begin
            errors++;
            $display("FAIL stall_hold L%0d: got v=%0d d=%0d l=%0d want v=1 d=%0d l=%0d",
                     k + 1, m_valid[k], m_data[k], m_last[k], hold_d[k], hold_l[k]);
          end
        end
        stalled[k] = m_valid[k] && !m_ready;
        hold_d[k]  = m_data[k];
        hold_l[k]  = m_last[k];
        if (m_valid[k] && first_v[k] < 0)
          first_v[k] = cyc;
        if (m_valid[k] && m_ready) begin
          if (ncap[k] < 32) begin
            capd[k][ncap[k]] = m_data[k];
            capl[k][ncap[k]] = m_last[k];
          end
          if (ncap[k] == 0)
            first_a[k] = cyc;
          last_a[k] = cyc;
          ncap[k]++;
        end
        if (fdone[k]) begin
          ndone[k]++;
          done_cyc[k] = cyc;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      ncap[k]     = 0;
      rdcnt[k]    = 0;
      ndone[k]    = 0;
      first_v[k]  = -1;
      first_a[k]  = -1;
      last_a[k]   = -1;
      done_cyc[k] = -1;
      stalled[k]  = 1'b0;
    end
  endtask

  task automatic fifo_flush();
    fflush = 1'b1;
    tick();
    fflush = 1'b0;
  endtask

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[ftail & 63] = 11'(base + i);
      ftail++;
    end
  endtask

  task automatic pulse_start(input int len);
    frame_len = 14'(len);
    start     = 1'b1;
    tick();
    start      = 1'b0;
    start_edge = cyc;
  endtask

  task automatic wait_done(input int maxc, input int rdy);
    for (int c = 0; c < maxc && !(ndone[0] > 0 && ndone[1] > 0); c++) begin
      m_ready = (rdy == 0) ? 1'b1 : ((c % 2) == 0);
      tick();
    end
    m_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic check_frame(input int n, input int base);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("done_cnt L%0d", k + 1), ndone[k], 1);
      chk($sformatf("xfer_cnt L%0d", k + 1), ncap[k], n);
      chk($sformatf("rd_cnt L%0d", k + 1), rdcnt[k], n);
      for (int j = 0; j < n && j < 32; j++) begin
        chk($sformatf("data L%0d #%0d", k + 1, j), int'(capd[k][j]), base + j);
        chk($sformatf("last L%0d #%0d", k + 1, j), int'(capl[k][j]), int'(j == n - 1));
      end
      chk($sformatf("busy_end L%0d", k + 1), int'(busy[k]), 0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    fifo_flush();
    clear_mon();
    load(v.base, v.n);
    m_ready = 1'b1;
    pulse_start(v.len);
    wait_done(300, v.rdy);
    check_frame(v.n, v.base);
    if (v.rdy == 0) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("first_valid_lat L%0d", k + 1), first_v[k] - start_edge, k + 2);
        chk($sformatf("throughput L%0d", k + 1), last_a[k] - first_a[k], v.n - 1);
        chk($sformatf("done_lag L%0d", k + 1), done_cyc[k] - last_a[k], 1);
      end
    end
  endtask

  initial begin
    vecs[0] = '{len: 16, rdy: 0, n: 16, base: 0};
    vecs[1] = '{len: 8,  rdy: 1, n: 8,  base: 0};
    vecs[2] = '{len: 0,  rdy: 0, n: 1,  base: 100};
    vecs[3] = '{len: 1,  rdy: 1, n: 1,  base: 200};
    vecs[4] = '{len: 5,  rdy: 1, n: 5,  base: 300};
    vecs[5] = '{len: 3,  rdy: 0, n: 3,  base: 2040};

    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    m_ready   = 1'b1;
    frame_len = '0;
    clear_mon();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_out L%0d", k + 1),
          int'({rd_en[k], m_valid[k], m_last[k], busy[k], fdone[k]}), 0);
      chk($sformatf("rst_data L%0d", k + 1), int'(m_data[k]), 0);
    end
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++)
      run_vec(vecs[i]);

    // Empty stall with an ignored start in the middle of the frame
    fifo_flush();
    clear_mon();
    load(500, 3);
    m_ready = 1'b1;
    pulse_start(6);
    repeat (5) tick();
    frame_len = 14'd2;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("stall_rd L%0d", k + 1), rdcnt[k], 3);
      chk($sformatf("stall_busy L%0d", k + 1), int'(busy[k]), 1);
      chk($sformatf("stall_xfer L%0d", k + 1), ncap[k], 3);
    end
    load(503, 3);
    wait_done(100, 0);
    check_frame(6, 500);

    // Abort after four accepted samples
    fifo_flush();
    clear_mon();
    load(600, 10);
    m_ready = 1'b1;
    pulse_start(10);
    for (int c = 0; c < 50 && ncap[0] < 4; c++)
      tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("abort_busy L%0d", k + 1), int'(busy[k]), 0);
      chk($sformatf("abort_valid L%0d", k + 1), int'(m_valid[k]), 0);
    end
    begin
      int rd0;
      int rd1;
      rd0 = rdcnt[0];
      rd1 = rdcnt[1];
      repeat (10) tick();
      chk("abort_xfer L1", ncap[0], 4);
      chk("abort_xfer L2 le4", int'(ncap[1] <= 4), 1);
      chk("abort_rd_quiet L1", rdcnt[0], rd0);
      chk("abort_rd_quiet L2", rdcnt[1], rd1);
      chk("abort_done L1", ndone[0], 0);
      chk("abort_done L2", ndone[1], 0);
    end
    run_vec('{len: 4, rdy: 0, n: 4, base: 700});

    // Reset in the middle of a frame
    fifo_flush();
    clear_mon();
    load(800, 10);
    pulse_start(10);
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst_out L%0d", k + 1),
          int'({rd_en[k], m_valid[k], m_last[k], busy[k], fdone[k]}), 0);
      chk($sformatf("midrst_data L%0d", k + 1), int'(m_data[k]), 0);
    end
    tick();
    rst = 1'b0;
    tick();
    run_vec('{len: 4, rdy: 1, n: 4, base: 900});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
